// File: rtl/memory_bus_master_if.sv
// Core-side request/response handshake plus the memory_controller bus, grouped for the bus master.
// The master modport is the initiator's view; slave is the view of the core and memory together.
interface memory_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [1:0]  resp_region;

    logic [15:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_we;
    logic [31:0] mem_data_out;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready, mem_data_out,
        output req_ready, resp_valid, resp_rdata, resp_err, resp_region,
               mem_address, mem_data_in, mem_we
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, resp_ready, mem_data_out,
        input  req_ready, resp_valid, resp_rdata, resp_err, resp_region,
               mem_address, mem_data_in, mem_we
    );
endinterface

// File: rtl/memory_bus_master.sv
// Single-outstanding bus master: decode, hold the memory bus ACCESS_CYCLES cycles, respond.
// Response ACCESS_CYCLES+1 edges after accept (1 edge for rejected accesses); held until resp_ready.
module memory_bus_master #(
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter logic [15:0] ROM_LAST      = 16'h001F,
    parameter logic [15:0] IO_LAST       = 16'h003F,
    parameter logic [15:0] RAM_FIRST     = 16'h0800,
    parameter logic [15:0] RAM_LAST      = 16'h0FFF
) (
    input  logic                clock,
    input  logic                reset,
    memory_bus_master_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic [1:0] REGION_ROM      = 2'b00;
    localparam logic [1:0] REGION_IO       = 2'b01;
    localparam logic [1:0] REGION_RAM      = 2'b10;
    localparam logic [1:0] REGION_UNMAPPED = 2'b11;
    localparam logic [3:0] CNT_INIT        = 4'(ACCESS_CYCLES - 1);

    function automatic logic [1:0] decode_region(input logic [15:0] addr);
        if (addr <= ROM_LAST)
            return REGION_ROM;
        else if (addr <= IO_LAST)
            return REGION_IO;
        else if ((addr >= RAM_FIRST) && (addr <= RAM_LAST))
            return REGION_RAM;
        else
            return REGION_UNMAPPED;
    endfunction

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        launched_q, launched_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic [1:0]  resp_region_q, resp_region_d;

    logic [15:0] mem_address_q, mem_address_d;
    logic [31:0] mem_data_in_q, mem_data_in_d;
    logic        mem_we_q, mem_we_d;

    logic [1:0]  req_region;
    logic        req_illegal;

    assign req_region  = decode_region(bus.req_addr);
    assign req_illegal = (req_region == REGION_UNMAPPED) ||
                         (bus.req_we && (req_region == REGION_ROM));

    assign bus.req_ready   = (state_q == IDLE) && !reset;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_rdata  = resp_rdata_q;
    assign bus.resp_err    = resp_err_q;
    assign bus.resp_region = resp_region_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_data_in = mem_data_in_q;
    assign bus.mem_we      = mem_we_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        launched_d    = launched_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        resp_valid_d  = resp_valid_q;
        resp_rdata_d  = resp_rdata_q;
        resp_err_d    = resp_err_q;
        resp_region_d = resp_region_q;
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;
        mem_we_d      = mem_we_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d          = bus.req_we;
                    addr_d        = bus.req_addr;
                    wdata_d       = bus.req_wdata;
                    resp_region_d = req_region;
                    resp_rdata_d  = '0;
                    resp_valid_d  = 1'b0;
                    launched_d    = 1'b0;
                    if (req_illegal) begin
                        resp_err_d = 1'b1;
                        state_d    = RESP;
                    end else begin
                        resp_err_d = 1'b0;
                        cnt_d      = CNT_INIT;
                        state_d    = ACCESS;
                    end
                end
            end

            ACCESS: begin
                // First ACCESS edge launches the bus; the countdown runs on the following edges.
                if (!launched_q) begin
                    launched_d    = 1'b1;
                    mem_address_d = addr_q;
                    mem_data_in_d = we_q ? wdata_q : '0;
                    mem_we_d      = we_q;
                end else if (cnt_q == 4'd0) begin
                    resp_rdata_d  = we_q ? '0 : bus.mem_data_out;
                    resp_err_d    = 1'b0;
                    resp_valid_d  = 1'b1;
                    mem_address_d = '0;
                    mem_data_in_d = '0;
                    mem_we_d      = 1'b0;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            RESP: begin
                // Rejected accesses enter RESP with valid low and raise it on the next edge.
                if (!resp_valid_q) begin
                    resp_valid_d = 1'b1;
                end else if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            launched_q    <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= '0;
            resp_err_q    <= 1'b0;
            resp_region_q <= '0;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
            mem_we_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            launched_q    <= launched_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_err_q    <= resp_err_d;
            resp_region_q <= resp_region_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
            mem_we_q      <= mem_we_d;
        end
    end

endmodule

// File: tb/tb_memory_bus_master.sv
// Directed bench for memory_bus_master with a behavioural memory that returns a tagged address.
module tb_memory_bus_master;
    localparam int AC = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    memory_bus_master_if bus ();

    memory_bus_master #(.ACCESS_CYCLES(AC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    always_comb bus.mem_data_out = (bus.mem_address == 16'h0805) ? 32'hDEADBEEF
                                                                 : {16'hA5A5, bus.mem_address};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic we, input logic [15:0] addr, input logic [31:0] wdata);
        chk("req_ready_before_accept", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        tick();
        bus.req_valid = 1'b0;
        bus.req_we    = ~we;
        bus.req_addr  = ~addr;
        bus.req_wdata = ~wdata;
        chk("req_ready_after_accept", 32'(bus.req_ready), 32'd0);
        chk("resp_valid_at_accept", 32'(bus.resp_valid), 32'd0);
        chk("mem_we_at_accept", 32'(bus.mem_we), 32'd0);
        chk("mem_address_at_accept", 32'(bus.mem_address), 32'd0);
    endtask

    task automatic finish_resp(input logic [1:0] region, input logic err, input logic [31:0] rdata);
        chk("resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("resp_rdata", bus.resp_rdata, rdata);
        chk("resp_err", 32'(bus.resp_err), 32'(err));
        chk("resp_region", 32'(bus.resp_region), 32'(region));
        chk("mem_we_in_resp", 32'(bus.mem_we), 32'd0);
        chk("mem_address_in_resp", 32'(bus.mem_address), 32'd0);
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        chk("resp_valid_after_consume", 32'(bus.resp_valid), 32'd0);
        chk("req_ready_after_consume", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic run_ok(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                          input logic [1:0] region, input logic [31:0] rdata);
        accept(we, addr, wdata);
        for (int i = 0; i < AC; i++) begin
            tick();
            chk("mem_address_held", 32'(bus.mem_address), 32'(addr));
            chk("mem_we_held", 32'(bus.mem_we), 32'(we));
            chk("mem_data_in_held", bus.mem_data_in, we ? wdata : 32'd0);
            chk("resp_valid_during_access", 32'(bus.resp_valid), 32'd0);
        end
        tick();
        finish_resp(region, 1'b0, we ? 32'd0 : rdata);
    endtask

    task automatic run_err(input logic we, input logic [15:0] addr, input logic [1:0] region);
        accept(we, addr, 32'h1234_5678);
        tick();
        finish_resp(region, 1'b1, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;

        // Reset state while reset is held high.
        tick();
        tick();
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_resp_region", 32'(bus.resp_region), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_mem_address", 32'(bus.mem_address), 32'd0);
        chk("rst_mem_data_in", bus.mem_data_in, 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_req_ready", 32'(bus.req_ready), 32'd1);

        // Load from RAM, store to I/O.
        run_ok(1'b0, 16'h0805, 32'd0, 2'b10, 32'hDEADBEEF);
        run_ok(1'b1, 16'h0021, 32'h0000_000A, 2'b01, 32'd0);

        // ROM store rejected, ROM load allowed.
        run_err(1'b1, 16'h0010, 2'b00);
        run_ok(1'b0, 16'h0010, 32'd0, 2'b00, 32'hA5A5_0010);

        // Decode boundaries.
        run_ok(1'b0, 16'h003F, 32'd0, 2'b01, 32'hA5A5_003F);
        run_err(1'b0, 16'h0040, 2'b11);
        run_err(1'b0, 16'h07FF, 2'b11);
        run_ok(1'b0, 16'h0800, 32'd0, 2'b10, 32'hA5A5_0800);
        run_ok(1'b0, 16'h0FFF, 32'd0, 2'b10, 32'hA5A5_0FFF);
        run_err(1'b0, 16'h1000, 2'b11);
        run_err(1'b1, 16'hFFFF, 2'b11);

        // Response backpressure with a competing request.
        accept(1'b0, 16'h0801, 32'd0);
        repeat (AC) tick();
        tick();
        chk("bp_resp_valid_rise", 32'(bus.resp_valid), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 16'h0802;
        bus.req_wdata = 32'h0000_0055;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_resp_valid_held", 32'(bus.resp_valid), 32'd1);
            chk("bp_resp_rdata_held", bus.resp_rdata, 32'hA5A5_0801);
            chk("bp_req_ready_low", 32'(bus.req_ready), 32'd0);
            chk("bp_mem_we_low", 32'(bus.mem_we), 32'd0);
        end
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        chk("bp_resp_valid_drop", 32'(bus.resp_valid), 32'd0);
        chk("bp_req_ready_idle", 32'(bus.req_ready), 32'd1);
        chk("bp_not_accepted_yet", 32'(bus.mem_we), 32'd0);
        tick();
        bus.req_valid = 1'b0;
        chk("bp_second_accepted", 32'(bus.req_ready), 32'd0);
        for (int i = 0; i < AC; i++) begin
            tick();
            chk("bp2_mem_we", 32'(bus.mem_we), 32'd1);
            chk("bp2_mem_address", 32'(bus.mem_address), 32'h0802);
            chk("bp2_mem_data_in", bus.mem_data_in, 32'h0000_0055);
        end
        tick();
        finish_resp(2'b10, 1'b0, 32'd0);

        // Reset during a store access drops the request.
        accept(1'b1, 16'h0900, 32'h0000_0077);
        tick();
        chk("mid_mem_we_active", 32'(bus.mem_we), 32'd1);
        reset = 1'b1;
        tick();
        chk("mid_rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("mid_rst_mem_address", 32'(bus.mem_address), 32'd0);
        chk("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_no_resp", 32'(bus.resp_valid), 32'd0);
            chk("post_rst_mem_we", 32'(bus.mem_we), 32'd0);
        end
        run_ok(1'b0, 16'h0900, 32'd0, 2'b10, 32'hA5A5_0900);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
